// File: rtl/inst_fetch_buffer_if.sv
// Fetch-side bundle: PC/hold, memory request/response and decode handshake.
// Latency: none; this is wiring only.
// Backpressure: carries hold_o to the PC, mem_req_ready_i from memory and id_ready_i from decode.
// Ports: slave = fetch buffer view; master = PC/memory/decode environment view.
interface inst_fetch_buffer_if;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        hold_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_req_addr_o;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_inst_o;
    logic [31:0] id_pc_o;

    modport slave (
        input  pc_i, flush_i, mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, id_ready_i,
        output hold_o, mem_req_valid_o, mem_req_addr_o, id_valid_o, id_inst_o, id_pc_o
    );

    modport master (
        output pc_i, flush_i, mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, id_ready_i,
        input  hold_o, mem_req_valid_o, mem_req_addr_o, id_valid_o, id_inst_o, id_pc_o
    );
endinterface

// File: rtl/inst_fetch_buffer.sv
// In-order instruction fetch buffer pairing each memory response with its PC.
// Latency: response captured at an edge is presented to decode the following cycle (request->decode >= 2 cycles).
// Backpressure: credit-limited requests (buffered + in-flight + to-drop <= DEPTH); hold_o stalls the PC; decode via valid/ready.
// Ports: clk, rst (sync, active-high), bus (inst_fetch_buffer_if.slave: PC/flush/hold, mem req/rsp, decode).
module inst_fetch_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_fetch_buffer_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    alloc_ptr_q, alloc_ptr_d;
    logic [PW-1:0]    fill_ptr_q, fill_ptr_d;
    logic [PW-1:0]    head_ptr_q, head_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    drop_cnt_q, drop_cnt_d;
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [31:0]      pc_mem_q   [DEPTH];
    logic [31:0]      inst_mem_q [DEPTH];

    logic [CW-1:0] filled_num;
    logic [CW-1:0] unfilled_num;
    logic [CW:0]   drop_sum;
    logic          credit;
    logic          req_fire;
    logic          rsp_drop;
    logic          rsp_fill;
    logic          id_valid;
    logic          pop;

    // Every filled entry is allocated (pop clears filled), so unfilled = count - filled.
    always_comb begin
        filled_num = '0;
        for (int i = 0; i < DEPTH; i++) begin
            filled_num = filled_num + CW'(filled_q[i]);
        end
    end
    assign unfilled_num = count_q - filled_num;

    // Stale responses still owed by memory occupy credit until they are dropped.
    assign credit   = ({1'b0, count_q} + {1'b0, drop_cnt_q}) < (CW+1)'(DEPTH);
    assign req_fire = bus.mem_req_valid_o & bus.mem_req_ready_i;
    assign rsp_drop = bus.mem_rsp_valid_i & (drop_cnt_q != '0);
    assign rsp_fill = bus.mem_rsp_valid_i & (drop_cnt_q == '0) & (unfilled_num != '0);
    assign id_valid = ~rst & (count_q != '0) & filled_q[head_ptr_q];
    assign pop      = id_valid & bus.id_ready_i;

    assign bus.mem_req_valid_o = credit & ~bus.flush_i & ~rst;
    assign bus.mem_req_addr_o  = bus.pc_i;
    assign bus.hold_o          = ~req_fire;
    assign bus.id_valid_o      = id_valid;
    // Zeroed when idle so stale slot contents never leak after reset.
    assign bus.id_pc_o         = id_valid ? pc_mem_q[head_ptr_q]   : '0;
    assign bus.id_inst_o       = id_valid ? inst_mem_q[head_ptr_q] : '0;

    always_comb begin
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        head_ptr_d  = head_ptr_q;
        count_d     = count_q;
        drop_cnt_d  = drop_cnt_q;
        filled_d    = filled_q;
        drop_sum    = {1'b0, drop_cnt_q} + {1'b0, unfilled_num};
        if (bus.flush_i) begin
            // A response landing in the flush cycle answers one of the owed requests.
            if (bus.mem_rsp_valid_i && (drop_sum != '0)) begin
                drop_sum = drop_sum - (CW+1)'(1);
            end
            drop_cnt_d  = drop_sum[CW-1:0];
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            head_ptr_d  = '0;
            count_d     = '0;
            filled_d    = '0;
        end else begin
            if (req_fire) begin
                filled_d[alloc_ptr_q] = 1'b0;
                alloc_ptr_d = alloc_ptr_q + PW'(1);
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (rsp_fill) begin
                filled_d[fill_ptr_q] = 1'b1;
                fill_ptr_d = fill_ptr_q + PW'(1);
            end
            if (pop) begin
                filled_d[head_ptr_q] = 1'b0;
                head_ptr_d = head_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(req_fire) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            count_q     <= '0;
            drop_cnt_q  <= '0;
            filled_q    <= '0;
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
            count_q     <= count_d;
            drop_cnt_q  <= drop_cnt_d;
            filled_q    <= filled_d;
        end
    end

    // Payload storage needs no reset: filled/count gate every read.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_mem_q[alloc_ptr_q] <= bus.pc_i;
        end
        if (rsp_fill && !bus.flush_i && !rst) begin
            inst_mem_q[fill_ptr_q] <= bus.mem_rsp_data_i;
        end
    end
endmodule

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
- Consumer end of the program counter interface.
- Takes the current fetch address pc_i and issues in-order read requests to instruction memory. Returns hold_o to the PC so that it advances only when a request is accepted.
- Pairs each memory response with its PC in a DEPTH-entry in-order buffer, then presents {pc, inst} to decode with a valid/ready handshake.
- flush_i (the same jump_en that redirects the PC) discards buffered entries and in-flight responses.

Parameters:
DEPTH, 4, number of buffer entries and the maximum number of outstanding plus buffered fetches; power of 2, at least 2.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
pc_i  in  32  current PC value; the fetch address
flush_i  in  1  redirect; discard all fetch state this cycle
hold_o  out  1  1 = PC must not advance this cycle; integrator zero-extends onto the PC hold bus
mem_req_valid_o  out  1  read request valid
mem_req_ready_i  in  1  memory accepts request
mem_req_addr_o  out  32  request address, equal to pc_i
mem_rsp_valid_i  in  1  read data valid; responses return in request order, one per accepted request, latency of 1 or more cycles
mem_rsp_data_i  in  32  instruction word
id_valid_o  out  1  instruction available to decode
id_ready_i  in  1  decode accepts
id_inst_o  out  32  instruction
id_pc_o  out  32  PC of id_inst_o

Behaviour:
State:
- Circular buffer of DEPTH entries, each holding {pc[31:0], inst[31:0], filled}.
- Three pointers: alloc_ptr, fill_ptr and head_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH.
- count, in 0..DEPTH: number of allocated entries.
- drop_cnt, in 0..DEPTH: number of responses still to be discarded.

Reset (rst=1, synchronous, overriding all other inputs):
- Pointers, count, drop_cnt and all filled bits are cleared.
- Outputs during and after reset: mem_req_valid_o=0, id_valid_o=0, hold_o=1, id_inst_o=0, id_pc_o=0.
- Memory is reset by the same rst, so no pre-reset responses return.

Request issue:
- credit = (count + drop_cnt < DEPTH).
- mem_req_valid_o = credit & ~flush_i & ~rst. This is combinational.
- mem_req_addr_o = pc_i.
- On accept (valid & ready): write entry[alloc_ptr] with pc=pc_i and filled=0, increment alloc_ptr, increment count.
- hold_o = ~(mem_req_valid_o & mem_req_ready_i). The PC therefore advances by 4 exactly once per accepted request.
- No allocation occurs when count reaches DEPTH, even if a pop happens in the same cycle. There is no same-cycle bypass of credit.

Response handling:
- If mem_rsp_valid_i and drop_cnt>0: discard the response and decrement drop_cnt.
- Otherwise, on mem_rsp_valid_i: write inst=mem_rsp_data_i into entry[fill_ptr], set filled=1, increment fill_ptr.
- A response arriving with no unfilled allocated entry and drop_cnt==0 is a protocol error and is ignored. No state changes.

Decode output:
- id_valid_o = count>0 & entry[head_ptr].filled.
- id_pc_o and id_inst_o come from entry[head_ptr] and must hold stable while valid & ~ready.
- On pop (valid & ready): clear filled, increment head_ptr, decrement count.
- Latency: a response captured at edge N drives id_valid_o high after edge N (registered), so it is visible in the cycle after the response cycle. A request accepted at cycle N with 1-cycle memory is therefore visible at cycle N+2.
- There is no combinational path from mem_rsp to id outputs.

Flush (flush_i=1, no rst):
- Takes priority over pop, allocate and fill.
- Set drop_cnt to (drop_cnt + unfilled_count − (mem_rsp_valid_i ? 1 : 0)), where unfilled_count = allocated entries with filled=0. A response in the flush cycle is itself discarded.
- Clear all pointers, count and filled bits.
- No request is issued and hold_o=1 in the flush cycle. The PC loads the jump target that cycle, so fetch resumes from the target on the next cycle.
- id_valid_o goes low on the cycle after flush. A pop handshake coinciding with flush is honoured by decode but has no buffer effect.

Simultaneous events (no flush): allocate, fill and pop may all occur in one cycle and each applies independently. count changes by (+alloc − pop).

Test Plan:
- Reset with rst=1 for 2 cycles -> hold_o=1, mem_req_valid_o=0, id_valid_o=0. After release with mem ready and 1-cycle memory and id_ready_i=1 -> requests 0x0,0x4,0x8 on consecutive cycles; id outputs (pc,inst) in order, first valid 2 cycles after the first request.
- Backpressure: id_ready_i=0, memory always ready -> exactly DEPTH=4 requests (0x0..0xC), then hold_o=1 with count=4. Raise id_ready_i -> 0x0 pops, and the next request 0x10 issues the cycle after the pop.
- mem_req_ready_i=0 for 3 cycles -> hold_o=1 and pc_i stable; request 0x4 is issued once when ready returns, with no duplicate.
- Flush with 2 requests outstanding and 3-cycle memory: flush_i=1 with pc_i=0x100 on the next cycle -> the next 2 responses are discarded. First id output is pc 0x100 with its matching instruction.
- Flush coinciding with mem_rsp_valid_i and 1 other outstanding request -> drop_cnt=1; exactly one later response is dropped.
- rst asserted mid-stream with 3 entries filled and id_ready_i=0 -> id_valid_o=0 the next cycle. Post-reset fetch restarts at 0x0 with drop_cnt=0.
